// File: rtl/regfile_dmem_addsub.sv
// Storage-and-arithmetic datapath core: a 32-entry register file, a small data memory
// and a combinational adder/subtractor. The three blocks share only the clock and reset.

module register_file #(
   parameter int W = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_we,
   input  logic [4:0]   i_waddr,
   input  logic [W-1:0] i_wdata,
   input  logic [4:0]   i_addr_a,
   input  logic [4:0]   i_addr_b,
   output logic [W-1:0] o_data_a,
   output logic [W-1:0] o_data_b
);

   logic [W-1:0] r_regs [0:31];

   // Index 0 is ordinary storage; there is no hardwired zero register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // No bypass: a read of the register being written returns the old value until the edge.
   assign o_data_a = r_regs[i_addr_a];
   assign o_data_b = r_regs[i_addr_b];

endmodule

module data_memory #(
   parameter int W    = 64,
   parameter int SIZE = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [4:0]   i_addr,
   input  logic [W-1:0] i_wdata,
   input  logic         i_we,
   input  logic         i_rd,
   output logic [W-1:0] o_rdata
);

   localparam logic [5:0] SIZE_W = 6'(SIZE);

   logic [W-1:0] r_mem [0:SIZE-1];
   logic [W-1:0] r_dout;
   logic         w_in_range;

   assign w_in_range = ({1'b0, i_addr} < SIZE_W);

   // Read and write share one block so a simultaneous read captures the pre-write word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < SIZE; i++) begin
            r_mem[i] <= '0;
         end
         r_dout <= '0;
      end else begin
         if (i_we && w_in_range) begin
            r_mem[i_addr] <= i_wdata;
         end
         if (i_rd) begin
            r_dout <= w_in_range ? r_mem[i_addr] : '0;
         end
      end
   end

   assign o_rdata = r_dout;

endmodule

module adder_subtractor #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_result,
   output logic         o_overflow
);

   logic [W-1:0] w_b_eff;
   logic [W-1:0] w_sum;

   // Subtraction is A + ~B + 1, so overflow reduces to the add rule on the effective operand.
   assign w_b_eff    = i_sub ? ~i_b : i_b;
   assign w_sum      = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};
   assign o_result   = w_sum;
   assign o_overflow = (i_a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != i_a[W-1]);

endmodule

module regfile_dmem_addsub #(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rf_write_en,
   input  logic [4:0]          rf_write_addr,
   input  logic [WORDSIZE-1:0] rf_write_data,
   input  logic [4:0]          rf_addr_a,
   input  logic [4:0]          rf_addr_b,
   output logic [WORDSIZE-1:0] rf_data_a,
   output logic [WORDSIZE-1:0] rf_data_b,
   input  logic [4:0]          dm_addr,
   input  logic [WORDSIZE-1:0] dm_data_input,
   input  logic                dm_write_enable,
   input  logic                dm_read,
   output logic [WORDSIZE-1:0] dm_data_output,
   input  logic [WORDSIZE-1:0] as_factor_a,
   input  logic [WORDSIZE-1:0] as_factor_b,
   input  logic                as_operation,
   output logic [WORDSIZE-1:0] as_result,
   output logic                as_overflow
);

   register_file #(.W(WORDSIZE)) u_rf (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_we     (rf_write_en),
      .i_waddr  (rf_write_addr),
      .i_wdata  (rf_write_data),
      .i_addr_a (rf_addr_a),
      .i_addr_b (rf_addr_b),
      .o_data_a (rf_data_a),
      .o_data_b (rf_data_b)
   );

   data_memory #(.W(WORDSIZE), .SIZE(SIZE)) u_dm (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_addr  (dm_addr),
      .i_wdata (dm_data_input),
      .i_we    (dm_write_enable),
      .i_rd    (dm_read),
      .o_rdata (dm_data_output)
   );

   adder_subtractor #(.W(WORDSIZE)) u_as (
      .i_a        (as_factor_a),
      .i_b        (as_factor_b),
      .i_sub      (as_operation),
      .o_result   (as_result),
      .o_overflow (as_overflow)
   );

endmodule

// File: tb/tb_regfile_dmem_addsub.sv
// Randomized bench for regfile_dmem_addsub: a driver issues one stimulus per cycle and
// queues expected outputs from an array-based model; a negedge monitor pops and compares.

module tb_regfile_dmem_addsub;

   localparam int W    = 64;
   localparam int SIZE = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         rf_write_en;
   logic [4:0]   rf_write_addr;
   logic [W-1:0] rf_write_data;
   logic [4:0]   rf_addr_a;
   logic [4:0]   rf_addr_b;
   logic [W-1:0] rf_data_a;
   logic [W-1:0] rf_data_b;
   logic [4:0]   dm_addr;
   logic [W-1:0] dm_data_input;
   logic         dm_write_enable;
   logic         dm_read;
   logic [W-1:0] dm_data_output;
   logic [W-1:0] as_factor_a;
   logic [W-1:0] as_factor_b;
   logic         as_operation;
   logic [W-1:0] as_result;
   logic         as_overflow;

   regfile_dmem_addsub #(.WORDSIZE(W), .SIZE(SIZE)) dut (
      .clk             (clk),
      .rst             (rst),
      .rf_write_en     (rf_write_en),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .rf_addr_a       (rf_addr_a),
      .rf_addr_b       (rf_addr_b),
      .rf_data_a       (rf_data_a),
      .rf_data_b       (rf_data_b),
      .dm_addr         (dm_addr),
      .dm_data_input   (dm_data_input),
      .dm_write_enable (dm_write_enable),
      .dm_read         (dm_read),
      .dm_data_output  (dm_data_output),
      .as_factor_a     (as_factor_a),
      .as_factor_b     (as_factor_b),
      .as_operation    (as_operation),
      .as_result       (as_result),
      .as_overflow     (as_overflow)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus record
   typedef struct {
      logic         rst;
      logic         rf_we;
      logic [4:0]   wa;
      logic [W-1:0] wd;
      logic [4:0]   aa;
      logic [4:0]   ab;
      logic [4:0]   dm_addr;
      logic [W-1:0] dm_din;
      logic         dm_we;
      logic         dm_rd;
      logic [W-1:0] fa;
      logic [W-1:0] fb;
      logic         op;
   } stim_t;

   typedef struct {
      int           due;
      int           kind;
      logic [W-1:0] val;
   } exp_t;

   exp_t exp_q[$];

   // reference model
   logic [W-1:0] ref_regs [0:31];
   logic [W-1:0] ref_mem  [0:31];
   logic [W-1:0] ref_dout;
   bit           ref_known = 1'b0;

   int total = 0;
   int bad   = 0;

   function automatic stim_t idle();
      stim_t s;
      s.rst = 0; s.rf_we = 0; s.wa = 0; s.wd = 0; s.aa = 0; s.ab = 0;
      s.dm_addr = 0; s.dm_din = 0; s.dm_we = 0; s.dm_rd = 0;
      s.fa = 0; s.fb = 0; s.op = 0;
      return s;
   endfunction

   // Exact signed arithmetic one bit wider; overflow when the true value leaves W bits.
   function automatic logic [W:0] ref_addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic op);
      logic signed [W:0] full;
      logic [W:0]        r;
      if (op) full = $signed({a[W-1], a}) - $signed({b[W-1], b});
      else    full = $signed({a[W-1], a}) + $signed({b[W-1], b});
      r = {full[W] ^ full[W-1], full[W-1:0]};
      return r;
   endfunction

   function automatic void push(input int due, input int kind, input logic [W-1:0] val);
      exp_t e;
      e.due = due; e.kind = kind; e.val = val;
      exp_q.push_back(e);
   endfunction

   // driver
   task automatic drive(input stim_t s);
      logic [W:0] ar;
      @(posedge clk);
      #1;
      rst = s.rst; rf_write_en = s.rf_we; rf_write_addr = s.wa; rf_write_data = s.wd;
      rf_addr_a = s.aa; rf_addr_b = s.ab; dm_addr = s.dm_addr; dm_data_input = s.dm_din;
      dm_write_enable = s.dm_we; dm_read = s.dm_rd;
      as_factor_a = s.fa; as_factor_b = s.fb; as_operation = s.op;
      if (ref_known) begin
         push(cyc, 0, ref_regs[s.aa]);
         push(cyc, 1, ref_regs[s.ab]);
      end
      ar = ref_addsub(s.fa, s.fb, s.op);
      push(cyc, 2, ar[W-1:0]);
      push(cyc, 3, {{(W-1){1'b0}}, ar[W]});
      if (s.rst) begin
         for (int i = 0; i < 32; i++) begin
            ref_regs[i] = '0;
            ref_mem[i]  = '0;
         end
         ref_dout  = '0;
         ref_known = 1'b1;
      end else begin
         if (s.dm_rd) ref_dout = (int'(s.dm_addr) < SIZE) ? ref_mem[s.dm_addr] : '0;
         if (s.dm_we && int'(s.dm_addr) < SIZE) ref_mem[s.dm_addr] = s.dm_din;
         if (s.rf_we) ref_regs[s.wa] = s.wd;
      end
      if (ref_known) push(cyc + 1, 4, ref_dout);
   endtask

   // scoreboard monitor
   string kname [0:4] = '{"rf_data_a", "rf_data_b", "as_result", "as_overflow", "dm_data_output"};

   always @(negedge clk) begin
      int i;
      logic [W-1:0] act;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].due == cyc) begin
            case (exp_q[i].kind)
               0:       act = rf_data_a;
               1:       act = rf_data_b;
               2:       act = as_result;
               3:       act = {{(W-1){1'b0}}, as_overflow};
               default: act = dm_data_output;
            endcase
            total++;
            if (act !== exp_q[i].val) begin
               bad++;
               $display("FAIL %s cycle=%0d got=%h expected=%h", kname[exp_q[i].kind], cyc,
                        act, exp_q[i].val);
            end
            exp_q.delete(i);
         end else if (exp_q[i].due < cyc) begin
            total++;
            bad++;
            $display("FAIL stale_%s due=%0d now=%0d", kname[exp_q[i].kind], exp_q[i].due, cyc);
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
         1:       v = 64'h8000_0000_0000_0000;
         2:       v = '0;
         3:       v = '1;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      stim_t s;
      s = idle();
      rst = 0; rf_write_en = 0; rf_write_addr = 0; rf_write_data = 0;
      rf_addr_a = 0; rf_addr_b = 0; dm_addr = 0; dm_data_input = 0;
      dm_write_enable = 0; dm_read = 0; as_factor_a = 0; as_factor_b = 0; as_operation = 0;

      // reset clear
      s = idle(); s.rst = 1; drive(s);
      s = idle(); s.aa = 5; s.dm_rd = 1; s.dm_addr = 3; drive(s);

      // register write: old value before the edge, new value after, on both ports
      s = idle(); s.rf_we = 1; s.wa = 4; s.wd = 64'h0123_4567_89AB_CDEF; s.aa = 4; drive(s);
      s = idle(); s.aa = 4; s.ab = 4; drive(s);

      // memory latency and hold
      s = idle(); s.dm_we = 1; s.dm_addr = 7; s.dm_din = 64'hDEAD_BEEF; drive(s);
      s = idle(); s.dm_rd = 1; s.dm_addr = 7; drive(s);
      s = idle(); s.dm_addr = 12; drive(s);
      drive(s);

      // simultaneous read/write returns pre-write contents
      s = idle(); s.dm_we = 1; s.dm_addr = 2; s.dm_din = 10; drive(s);
      s = idle(); s.dm_we = 1; s.dm_rd = 1; s.dm_addr = 2; s.dm_din = 20; drive(s);
      s = idle(); s.dm_rd = 1; s.dm_addr = 2; drive(s);

      // add/sub vectors
      s = idle(); s.fa = 5; s.fb = 3; s.op = 0; drive(s);
      s.op = 1; drive(s);
      s = idle(); s.fa = 3; s.fb = 5; s.op = 1; drive(s);
      s = idle(); s.fa = 64'h7FFF_FFFF_FFFF_FFFF; s.fb = 1; s.op = 0; drive(s);
      s = idle(); s.fa = 64'h8000_0000_0000_0000; s.fb = 1; s.op = 1; drive(s);

      // reset overrides simultaneous writes
      s = idle(); s.rf_we = 1; s.wa = 9; s.wd = 77; s.dm_we = 1; s.dm_addr = 9; s.dm_din = 77;
      drive(s);
      s.rst = 1; drive(s);
      s = idle(); s.aa = 9; s.ab = 4; s.dm_rd = 1; s.dm_addr = 9; drive(s);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         s = idle();
         s.rst     = ($urandom_range(0, 59) == 0);
         s.rf_we   = $urandom_range(0, 1);
         s.wa      = 5'($urandom_range(0, 31));
         s.wd      = rand_word();
         s.aa      = 5'($urandom_range(0, 31));
         s.ab      = $urandom_range(0, 3) == 0 ? s.wa : 5'($urandom_range(0, 31));
         s.dm_addr = 5'($urandom_range(0, 31));
         s.dm_din  = rand_word();
         s.dm_we   = $urandom_range(0, 1);
         s.dm_rd   = $urandom_range(0, 1);
         s.fa      = rand_word();
         s.fb      = rand_word();
         s.op      = $urandom_range(0, 1);
         drive(s);
      end

      repeat (3) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover_expectations got=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
